// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port read arbiter in front of a single shared, registered ROM.
// Round-robin or fixed priority selection, a fixed two-cycle read latency,
// and responses returned in grant order.
//
// last-grant state
//   state | meaning
//   LAST0 | port 0 was granted most recently; port 1 wins the next contention
//   LAST1 | port 1 was granted most recently (reset value); port 0 wins next
module rom_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata
);

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_t;

    last_t                 last_gnt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  prefer0;
    // Stage 1 of the tag pipeline, aligned with rom_rdata.
    logic                  s1_valid;
    logic                  s1_port;

    // Arbitration: port 0 wins contention under fixed priority or after a port 1 grant.
    always_comb begin
        prefer0  = (FIXED_PRIO != 0) || (last_gnt == LAST1);
        gnt0     = rst_n && req0 && (!req1 || prefer0);
        gnt1     = rst_n && req1 && !(req0 && prefer0);
        rom_addr = addr_hold;
        if (gnt0) begin
            rom_addr = addr0;
        end else if (gnt1) begin
            rom_addr = addr1;
        end
    end

    // Grant bookkeeping and tag pipeline; stage 2 is the rvalid pair itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt  <= LAST1;
            addr_hold <= '0;
            s1_valid  <= 1'b0;
            s1_port   <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                last_gnt  <= gnt1 ? LAST1 : LAST0;
                addr_hold <= rom_addr;
            end
            s1_valid <= gnt0 || gnt1;
            s1_port  <= gnt1;
            rvalid0  <= s1_valid && !s1_port;
            rvalid1  <= s1_valid && s1_port;
            if (s1_valid && !s1_port) begin
                rdata0 <= rom_rdata;
            end
            if (s1_valid && s1_port) begin
                rdata1 <= rom_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus, each behind its own 1-cycle ROM model.
module tb_rom_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [7:0]  addr0, addr1;

    logic        a_gnt0, a_gnt1, a_rv0, a_rv1;
    logic [23:0] a_rd0, a_rd1, a_rom_q;
    logic [7:0]  a_rom_addr;
    logic        b_gnt0, b_gnt1, b_rv0, b_rv1;
    logic [23:0] b_rd0, b_rd1, b_rom_q;
    logic [7:0]  b_rom_addr;

    int errors = 0;
    int checks = 0;

    rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(24), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .gnt0(a_gnt0), .gnt1(a_gnt1),
        .rvalid0(a_rv0), .rvalid1(a_rv1), .rdata0(a_rd0), .rdata1(a_rd1),
        .rom_addr(a_rom_addr), .rom_rdata(a_rom_q)
    );

    rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(24), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .gnt0(b_gnt0), .gnt1(b_gnt1),
        .rvalid0(b_rv0), .rvalid1(b_rv1), .rdata0(b_rd0), .rdata1(b_rd1),
        .rom_addr(b_rom_addr), .rom_rdata(b_rom_q)
    );

    // Registered ROM models: mem[a] = 24'hA50000 | a
    always @(posedge clk) begin
        a_rom_q <= 24'hA50000 | {16'h0, a_rom_addr};
        b_rom_q <= 24'hA50000 | {16'h0, b_rom_addr};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic step(input logic rn, input logic r0, input logic r1,
                        input logic [7:0] a0, input logic [7:0] a1);
        @(negedge clk);
        rst_n = rn;
        req0  = r0;
        req1  = r1;
        addr0 = a0;
        addr1 = a1;
        #1;
    endtask

    // Contention table: req0, req1, rr gnt0/gnt1/rv0/rv1, fp gnt0/gnt1/rv0/rv1
    logic [9:0] cont_tbl [0:7];

    initial begin
        cont_tbl[0] = 10'b11_1000_1000;
        cont_tbl[1] = 10'b11_0100_1000;
        cont_tbl[2] = 10'b11_1010_1010;
        cont_tbl[3] = 10'b11_0101_1010;
        cont_tbl[4] = 10'b01_0110_0110;
        cont_tbl[5] = 10'b00_0001_0010;
        cont_tbl[6] = 10'b00_0001_0001;
        cont_tbl[7] = 10'b00_0000_0000;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

        // Reset: grants forced low even with requests pending
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 1, 8'h33, 8'h44);
        check_eq("rst_gnt0", a_gnt0, 0);
        check_eq("rst_gnt1", a_gnt1, 0);
        check_eq("rst_rv0", a_rv0, 0);
        check_eq("rst_rd0", a_rd0, 0);
        check_eq("rst_rom_addr", a_rom_addr, 0);

        // Single request in the first cycle out of reset
        step(1, 1, 0, 8'h12, 8'h00);
        check_eq("single_gnt0", a_gnt0, 1);
        check_eq("single_gnt1", a_gnt1, 0);
        check_eq("single_rom_addr", a_rom_addr, 8'h12);
        step(1, 0, 0, 8'h00, 8'h00);
        check_eq("single_rv0_t1", a_rv0, 0);
        step(1, 0, 0, 8'h00, 8'h00);
        check_eq("single_rv0_t2", a_rv0, 1);
        check_eq("single_rd0_t2", a_rd0, 24'hA50012);
        check_eq("single_rv1_t2", a_rv1, 0);
        step(1, 0, 0, 8'h00, 8'h00);
        check_eq("single_rv0_t3", a_rv0, 0);
        check_eq("single_rd0_hold", a_rd0, 24'hA50012);

        // Contention from a fresh reset: round-robin and fixed priority
        step(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1, cont_tbl[i][9], cont_tbl[i][8], 8'h01, 8'h02);
            check_eq($sformatf("rr_gnt0_%0d", i), a_gnt0, cont_tbl[i][7]);
            check_eq($sformatf("rr_gnt1_%0d", i), a_gnt1, cont_tbl[i][6]);
            check_eq($sformatf("rr_rv0_%0d", i), a_rv0, cont_tbl[i][5]);
            check_eq($sformatf("rr_rv1_%0d", i), a_rv1, cont_tbl[i][4]);
            check_eq($sformatf("rr_rd0_%0d", i), a_rd0, (i >= 2) ? 24'hA50001 : 24'h0);
            check_eq($sformatf("rr_rd1_%0d", i), a_rd1, (i >= 3) ? 24'hA50002 : 24'h0);
            check_eq($sformatf("fp_gnt0_%0d", i), b_gnt0, cont_tbl[i][3]);
            check_eq($sformatf("fp_gnt1_%0d", i), b_gnt1, cont_tbl[i][2]);
            check_eq($sformatf("fp_rv0_%0d", i), b_rv0, cont_tbl[i][1]);
            check_eq($sformatf("fp_rv1_%0d", i), b_rv1, cont_tbl[i][0]);
        end

        // Back-to-back reads on port 0
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a;
            a = 8'h10 + 8'(i);
            step(1, (i < 3), 0, a, 8'h00);
            if (i < 3) begin
                check_eq($sformatf("b2b_gnt0_%0d", i), a_gnt0, 1);
                check_eq($sformatf("b2b_rom_addr_%0d", i), a_rom_addr, a);
            end
            if (i >= 2) begin
                check_eq($sformatf("b2b_rv0_%0d", i), a_rv0, 1);
                check_eq($sformatf("b2b_rd0_%0d", i), a_rd0, 24'hA50010 + 24'(i - 2));
            end
        end
        step(1, 0, 0, 8'h00, 8'h00);
        check_eq("b2b_rv0_end", a_rv0, 0);
        check_eq("b2b_rd0_end", a_rd0, 24'hA50012);

        // Reset while a port 1 read is in flight
        step(1, 0, 1, 8'h00, 8'h20);
        check_eq("mid_gnt1", a_gnt1, 1);
        check_eq("mid_rom_addr", a_rom_addr, 8'h20);
        step(0, 1, 1, 8'h21, 8'h22);
        check_eq("mid_rst_gnt0", a_gnt0, 0);
        check_eq("mid_rst_gnt1", a_gnt1, 0);
        check_eq("mid_rst_fp_gnt0", b_gnt0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 8'h00, 8'h00);
            check_eq($sformatf("mid_rv1_%0d", i), a_rv1, 0);
            check_eq($sformatf("mid_rd1_%0d", i), a_rd1, 0);
            check_eq($sformatf("mid_rom_addr_%0d", i), a_rom_addr, 0);
        end

        // Idle hold: address register keeps the last granted address
        step(1, 1, 0, 8'h7F, 8'h00);
        check_eq("idle_gnt0", a_gnt0, 1);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 8'h55, 8'hAA);
            check_eq($sformatf("idle_rom_addr_%0d", i), a_rom_addr, 8'h7F);
            check_eq($sformatf("idle_gnt_%0d", i), {a_gnt0, a_gnt1}, 2'b00);
            check_eq($sformatf("idle_rv_%0d", i), {a_rv0, a_rv1}, (i == 2) ? 2'b10 : 2'b00);
            if (i >= 2)
                check_eq($sformatf("idle_rd0_%0d", i), a_rd0, 24'hA5007F);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, ROM word width.
REQ-003 SHALL have parameter FIXED_PRIO, default 0, 0 = round-robin, 1 = port 0 always wins.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port req0 / req1  input  1  read request, held until granted.
REQ-007 SHALL have port addr0 / addr1  input  ADDR_WIDTH  request address, stable while reqN high.
REQ-008 SHALL have port gnt0 / gnt1  output  1  combinational, request accepted this cycle.
REQ-009 SHALL have port rvalid0 / rvalid1  output  1  one-cycle pulse, rdataN valid.
REQ-010 SHALL have port rdata0 / rdata1  output  DATA_WIDTH  read data returned to port N.
REQ-011 SHALL have port rom_addr  output  ADDR_WIDTH  address to the shared ROM, registered by the ROM on clk.
REQ-012 SHALL have port rom_rdata  input  DATA_WIDTH  ROM output, valid one cycle after rom_addr is sampled.

Function
REQ-013 SHALL grant at most one port per cycle; gnt0 and gnt1 never both high.
REQ-014 SHALL grant only when rst_n is high and the corresponding reqN is high.
REQ-015 SHALL keep a one-bit last-grant state, LAST0 or LAST1; it is updated only on a grant.
REQ-016 SHALL, with FIXED_PRIO=0 and both requests high, grant port 1 in LAST0 and port 0 in LAST1.
REQ-017 SHALL, with FIXED_PRIO=1 and both requests high, always grant port 0.
REQ-018 SHALL, when only one request is high, grant that port regardless of state.
REQ-019 SHALL drive rom_addr combinationally with the granted port's address in a grant cycle; otherwise with a held register of the last granted address.
REQ-020 SHALL sustain one grant per cycle, with back-to-back grants to either port or alternating ports, with no bubbles.
REQ-021 SHALL track each grant through a 2-stage tag pipeline (valid, port id).
- Stage 1 aligns with rom_rdata.
- Stage 2 aligns with the output registers.
REQ-022 SHALL, for a grant in cycle T, capture rom_rdata at the end of T+1 into rdataN and pulse rvalidN high during T+2: fixed latency 2 cycles.
REQ-023 SHALL return data in grant order; responses never reorder or merge.
REQ-024 SHALL hold rdataN unchanged except in the cycle it is loaded; the other port's rdata is unaffected.
REQ-025 SHALL ignore addrN when reqN is low; a request dropped before grant is simply not served.
REQ-026 SHALL NOT drive gnt, rvalid or any state from X; all storage is explicitly reset.

Reset
REQ-027 SHALL, while rst_n is low at a clock edge, clear the following.
- Tag pipeline valid bits, rvalid0, rvalid1 -> 0.
- rdata0, rdata1 -> 0.
- Address hold register -> 0.
- Last-grant state -> LAST1, so that port 0 wins the first contention.
REQ-028 SHALL force gnt0 = gnt1 = 0 combinationally while rst_n is low.
REQ-029 SHALL discard reads in flight when reset is asserted mid-operation; no rvalid pulse for them after rst_n returns high.
REQ-030 SHALL grant a request in the first cycle rst_n is high.

Verification
The bench models the ROM as a 1-cycle registered memory with mem[a] = 24'hA50000 | a.
REQ-031 Single request: req0=1, addr0=8'h12 for 1 cycle in T -> gnt0=1 in T; rvalid0=1 in T+2 only; rdata0=24'hA50012, held afterwards.
REQ-032 Round-robin contention, FIXED_PRIO=0: after reset, req0 and req1 held high with addr0=8'h01, addr1=8'h02.
- Grants in order 0,1,0,1.
- rvalid pulses alternate starting 2 cycles after the first grant.
- Data values are 24'hA50001 and 24'hA50002.
REQ-033 Fixed priority, FIXED_PRIO=1: both requests held high for 4 cycles -> gnt0 in all 4 cycles, gnt1 never; after req0 drops, gnt1 is given in the next cycle.
REQ-034 Back-to-back on one port: req0 high for 3 cycles with addr0 = 8'h10, 8'h11, 8'h12 -> rvalid0 high 3 consecutive cycles; rdata0 = 24'hA50010, A50011, A50012 in sequence.
REQ-035 Reset mid-flight: grant port 1 with addr1=8'h20, then rst_n=0 on the next edge for 1 cycle.
- No rvalid1 appears.
- rdata1 = 0 and rom_addr = 0 after reset.
- gnt=0 while rst_n is low.
REQ-036 Idle hold: after a grant with addr=8'h7F, drive no requests for 5 cycles -> rom_addr stays 8'h7F; no gnt or rvalid activity.
